// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32I pipeline.
// Issues lw/sw to the data cache over req/ready and stalls upstream while a
// miss is outstanding. A watchdog traps into a sticky error state if the cache
// never answers. The stage also resolves jal/jalr/blt/bge into a redirect plus
// flush, and holds the MEM/WB pipeline register.
module mem_stage #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] rs2In,
  input  logic [XLEN-1:0] immPcIn,
  input  logic [XLEN-1:0] pcAdd4In,
  input  logic [XLEN-1:0] aluIn,
  input  logic [4:0]      rdIn,
  input  logic            EscRegIn,
  input  logic            EscMemIn,
  input  logic            jumpIn,
  input  logic            bltIn,
  input  logic            bgeIn,
  input  logic            jalrIn,
  input  logic            lwIn,
  output logic            memReq,
  output logic            memWe,
  output logic [XLEN-1:0] memAddr,
  output logic [XLEN-1:0] memWdata,
  input  logic [XLEN-1:0] memRdata,
  input  logic            memReady,
  output logic            stallMem,
  output logic            flushOut,
  output logic [XLEN-1:0] pcTarget,
  output logic [4:0]      rdWb,
  output logic            EscRegWb,
  output logic [XLEN-1:0] wbData,
  output logic            memErr
);
  // A width of at least 1 keeps MAX_WAIT = 0 legal.
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_wb_q, rd_wb_d;
  logic            esc_reg_wb_q, esc_reg_wb_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            access;
  logic            taken;

  assign access   = lwIn | EscMemIn;
  assign memWe    = EscMemIn;
  assign memAddr  = aluIn;
  assign memWdata = rs2In;

  // Access FSM. A hit in IDLE finishes with no stall. A miss parks in WAIT
  // with the request held, while upstream keeps the operands stable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    memReq  = 1'b0;
    case (state_q)
      S_IDLE: begin
        memReq = access;
        if (access && !memReady) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        memReq = 1'b1;
        // memReady takes priority over the watchdog expiring.
        if (memReady)                     state_d = S_IDLE;
        else if (cnt_q == CW'(MAX_WAIT))  state_d = S_ERR;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      S_ERR:   memReq = 1'b0;
      default: state_d = S_IDLE;
    endcase
  end

  assign memErr   = (state_q == S_ERR);
  assign stallMem = (memReq & ~memReady) | memErr;

  // Branch/jump resolution. The jalr target has its LSB cleared.
  always_comb begin
    taken    = jumpIn | jalrIn | (bltIn & aluIn[0]) | (bgeIn & ~aluIn[0]);
    pcTarget = jalrIn ? {aluIn[XLEN-1:1], 1'b0} : immPcIn;
    flushOut = taken;
  end

  // MEM/WB next value. A stall inserts the harmless x0 bubble.
  always_comb begin
    rd_wb_d      = rdIn;
    esc_reg_wb_d = EscRegIn;
    if (lwIn)                 wb_data_d = memRdata;
    else if (jumpIn | jalrIn) wb_data_d = pcAdd4In;
    else                      wb_data_d = aluIn;
    if (stallMem) begin
      rd_wb_d      = 5'd0;
      esc_reg_wb_d = 1'b1;
      wb_data_d    = '0;
    end
  end

  // State and pipeline register update. Reset abandons any pending access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_wb_q      <= 5'd0;
      esc_reg_wb_q <= 1'b1;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_wb_q      <= rd_wb_d;
      esc_reg_wb_q <= esc_reg_wb_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign rdWb     = rd_wb_q;
  assign EscRegWb = esc_reg_wb_q;
  assign wbData   = wb_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. It runs with MAX_WAIT = 4, which keeps the
// watchdog scenario short.
module tb_mem_stage;
  localparam int XLEN = 32;

  logic            clk, reset;
  logic [XLEN-1:0] rs2In, immPcIn, pcAdd4In, aluIn, memRdata;
  logic [4:0]      rdIn;
  logic            EscRegIn, EscMemIn, jumpIn, bltIn, bgeIn, jalrIn, lwIn, memReady;
  logic            memReq, memWe, stallMem, flushOut, EscRegWb, memErr;
  logic [XLEN-1:0] memAddr, memWdata, pcTarget, wbData;
  logic [4:0]      rdWb;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .rs2In(rs2In), .immPcIn(immPcIn), .pcAdd4In(pcAdd4In),
    .aluIn(aluIn), .rdIn(rdIn), .EscRegIn(EscRegIn), .EscMemIn(EscMemIn),
    .jumpIn(jumpIn), .bltIn(bltIn), .bgeIn(bgeIn), .jalrIn(jalrIn), .lwIn(lwIn),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memReady(memReady), .stallMem(stallMem), .flushOut(flushOut),
    .pcTarget(pcTarget), .rdWb(rdWb), .EscRegWb(EscRegWb), .wbData(wbData), .memErr(memErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs2In = '0; immPcIn = '0; pcAdd4In = '0; aluIn = '0; memRdata = '0; rdIn = '0;
    EscRegIn = 0; EscMemIn = 0; jumpIn = 0; bltIn = 0; bgeIn = 0; jalrIn = 0;
    lwIn = 0; memReady = 0;
  endtask

  initial begin
    reset = 1'b0;
    clr();
    tick(); tick();
    chk("rst_rdWb", 32'(rdWb), 32'd0);
    chk("rst_esc", 32'(EscRegWb), 32'd1);
    chk("rst_wbData", wbData, 32'd0);
    chk("rst_memErr", 32'(memErr), 32'd0);
    chk("rst_memReq", 32'(memReq), 32'd0);
    reset = 1'b1;
    tick();

    // Load hit
    lwIn = 1; aluIn = 32'h100; rdIn = 5; EscRegIn = 1; memReady = 1; memRdata = 32'hDEADBEEF;
    #1;
    chk("hit_req", 32'(memReq), 32'd1);
    chk("hit_stall", 32'(stallMem), 32'd0);
    chk("hit_we", 32'(memWe), 32'd0);
    chk("hit_addr", memAddr, 32'h100);
    tick(); clr();
    chk("hit_rdWb", 32'(rdWb), 32'd5);
    chk("hit_esc", 32'(EscRegWb), 32'd1);
    chk("hit_wbData", wbData, 32'hDEADBEEF);

    // Load miss with 3 cycles of latency
    lwIn = 1; aluIn = 32'h104; rdIn = 7; EscRegIn = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_req", 32'(memReq), 32'd1);
      chk("miss_stall", 32'(stallMem), 32'd1);
      tick();
      chk("miss_bubble_rd", 32'(rdWb), 32'd0);
      chk("miss_bubble_data", wbData, 32'd0);
    end
    memReady = 1; memRdata = 32'hCAFEF00D;
    #1;
    chk("miss_done_req", 32'(memReq), 32'd1);
    chk("miss_done_stall", 32'(stallMem), 32'd0);
    tick(); clr();
    chk("miss_rdWb", 32'(rdWb), 32'd7);
    chk("miss_wbData", wbData, 32'hCAFEF00D);
    #1;
    chk("miss_no_reissue", 32'(memReq), 32'd0);

    // Store
    EscMemIn = 1; aluIn = 32'h200; rs2In = 32'h12345678; memReady = 1; EscRegIn = 0; rdIn = 3;
    #1;
    chk("st_we", 32'(memWe), 32'd1);
    chk("st_req", 32'(memReq), 32'd1);
    chk("st_addr", memAddr, 32'h200);
    chk("st_wdata", memWdata, 32'h12345678);
    chk("st_stall", 32'(stallMem), 32'd0);
    tick(); clr();
    chk("st_esc", 32'(EscRegWb), 32'd0);
    chk("st_rdWb", 32'(rdWb), 32'd3);
    chk("st_wbData", wbData, 32'h200);

    // Branches and jumps
    bltIn = 1; aluIn = 32'h1; immPcIn = 32'h40;
    #1;
    chk("blt_flush", 32'(flushOut), 32'd1);
    chk("blt_target", pcTarget, 32'h40);
    chk("blt_stall", 32'(stallMem), 32'd0);
    clr(); bgeIn = 1; aluIn = 32'h1;
    #1;
    chk("bge_nt_flush", 32'(flushOut), 32'd0);
    aluIn = 32'h0; immPcIn = 32'h60;
    #1;
    chk("bge_t_flush", 32'(flushOut), 32'd1);
    chk("bge_t_target", pcTarget, 32'h60);
    clr(); bltIn = 1; aluIn = 32'h0;
    #1;
    chk("blt_nt_flush", 32'(flushOut), 32'd0);
    clr(); jumpIn = 1; immPcIn = 32'h80; pcAdd4In = 32'h10; rdIn = 2; EscRegIn = 1;
    #1;
    chk("jal_flush", 32'(flushOut), 32'd1);
    chk("jal_target", pcTarget, 32'h80);
    tick(); clr();
    chk("jal_wbData", wbData, 32'h10);
    jalrIn = 1; aluIn = 32'h87; pcAdd4In = 32'h24; rdIn = 1; EscRegIn = 1; immPcIn = 32'h999;
    #1;
    chk("jalr_flush", 32'(flushOut), 32'd1);
    chk("jalr_target", pcTarget, 32'h86);
    tick(); clr();
    chk("jalr_wbData", wbData, 32'h24);
    chk("jalr_rdWb", 32'(rdWb), 32'd1);

    // memReady with no request is ignored
    memReady = 1;
    #1;
    chk("idle_rdy_req", 32'(memReq), 32'd0);
    chk("idle_rdy_stall", 32'(stallMem), 32'd0);
    tick(); clr();

    // memReady arriving when counter == MAX_WAIT wins over the watchdog
    lwIn = 1; rdIn = 8; EscRegIn = 1; memReady = 0;
    tick();                                 // IDLE -> WAIT, cnt 0
    for (int i = 0; i < 4; i++) tick();     // cnt 0..3 -> 4
    memReady = 1; memRdata = 32'h55AA55AA;
    #1;
    chk("race_stall", 32'(stallMem), 32'd0);
    chk("race_err", 32'(memErr), 32'd0);
    tick(); clr();
    chk("race_err_after", 32'(memErr), 32'd0);
    chk("race_wbData", wbData, 32'h55AA55AA);
    #1;
    chk("race_idle_req", 32'(memReq), 32'd0);

    // Watchdog: IDLE miss cycle, then 5 WAIT cycles, then ERR
    lwIn = 1; rdIn = 9; EscRegIn = 1; memReady = 0;
    #1;
    chk("wd_idle_stall", 32'(stallMem), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wd_wait_err", 32'(memErr), 32'd0);
      chk("wd_wait_stall", 32'(stallMem), 32'd1);
      tick();
    end
    chk("wd_err", 32'(memErr), 32'd1);
    chk("wd_err_stall", 32'(stallMem), 32'd1);
    chk("wd_err_req", 32'(memReq), 32'd0);
    memReady = 1;
    tick();
    chk("wd_sticky", 32'(memErr), 32'd1);
    chk("wd_sticky_stall", 32'(stallMem), 32'd1);
    chk("wd_bubble", 32'(rdWb), 32'd0);
    reset = 0;
    tick();
    reset = 1; clr();
    #1;
    chk("wd_clr_err", 32'(memErr), 32'd0);
    chk("wd_clr_stall", 32'(stallMem), 32'd0);
    chk("wd_clr_req", 32'(memReq), 32'd0);

    // Reset mid-WAIT abandons the request
    lwIn = 1; rdIn = 6; EscRegIn = 1; memReady = 0;
    tick(); tick();
    chk("rw_pending", 32'(memReq), 32'd1);
    reset = 0;
    tick();
    reset = 1; clr();
    #1;
    chk("rw_req", 32'(memReq), 32'd0);
    chk("rw_rdWb", 32'(rdWb), 32'd0);
    chk("rw_esc", 32'(EscRegWb), 32'd1);
    chk("rw_wbData", wbData, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs, issues lw/sw accesses to the data cache over a req/ready handshake, and stalls the pipeline on a cache miss.
- Resolves jal/jalr/blt/bge and generates the redirect plus flush.
- Holds the MEM/WB pipeline register feeding write-back.

Parameters:
- XLEN, 32, data/address width.
- MAX_WAIT, 255, cycles a pending access may wait for mem_ready before memErr; counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- rs2In  in  XLEN  store data (EX/MEM rs2Out)
- immPcIn  in  XLEN  PC+imm target (jal/branch)
- pcAdd4In  in  XLEN  link value
- aluIn  in  XLEN  ALU result: address for lw/sw, jalr target, compare result in bit0 for blt/bge
- rdIn  in  5  destination register
- EscRegIn, EscMemIn, jumpIn, bltIn, bgeIn, jalrIn, lwIn  in  1 each  control from EX/MEM
- memReq  out  1  cache request
- memWe  out  1  1 = store
- memAddr  out  XLEN  = aluIn
- memWdata  out  XLEN  = rs2In
- memRdata  in  XLEN  load data, valid when memReq && memReady && !memWe
- memReady  in  1  cache completes the current request
- stallMem  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- flushOut  out  1  flush IF/ID, ID/EX, EX/MEM
- pcTarget  out  XLEN  redirect PC, valid when flushOut=1
- rdWb  out  5  MEM/WB destination register
- EscRegWb  out  1  MEM/WB register write enable
- wbData  out  XLEN  MEM/WB write-back data
- memErr  out  1  sticky watchdog error

Behaviour:
- access = lwIn | EscMemIn. memWe = EscMemIn. memAddr and memWdata are combinational pass-throughs.
- FSM states:
  - IDLE: memReq = access. If access && !memReady, go to WAIT and load the counter with 0. If access && memReady, the access completes this cycle with zero stall.
  - WAIT: memReq = 1. Inputs are stable because upstream is held. On memReady, go to IDLE. Otherwise increment the counter; when counter == MAX_WAIT, go to ERR.
  - ERR: memReq = 0, stallMem = 1, memErr = 1. Left only by reset.
- stallMem = memReq && !memReady, plus 1 in ERR. It is deasserted in the same cycle memReady arrives, so the upstream stages advance at that edge. No access is ever issued twice.
- Branch resolution (combinational):
  - taken = jumpIn | jalrIn | (bltIn & aluIn[0]) | (bgeIn & ~aluIn[0]).
  - pcTarget = jalrIn ? {aluIn[XLEN-1:1],1'b0} : immPcIn.
  - flushOut = taken. Branch and jump instructions never access memory, so flushOut and stallMem are never both 1.
- MEM/WB register, updated on every clock edge:
  - Bubble (stallMem=1): rdWb = 0, EscRegWb = 1, wbData = 0. This is the pipeline's standard harmless x0 bubble.
  - Otherwise: rdWb = rdIn, EscRegWb = EscRegIn.
  - wbData = memRdata if lwIn; pcAdd4In if jumpIn|jalrIn; else aluIn.
- Reset (reset = 0 at a clock edge): state IDLE, counter 0, memErr 0, rdWb 0, EscRegWb 1, wbData 0. Reset mid-WAIT abandons the request: memReq drops the next cycle.
- Stores: EscRegIn is expected to be 0 and is passed through unchanged.
- Simultaneous events:
  - memReady arriving in the same cycle counter == MAX_WAIT: memReady wins and the FSM returns to IDLE.
  - memReady seen while not requesting: ignored.

Test Plan:
- Load hit: lwIn=1, aluIn=0x100, rdIn=5, memReady=1 same cycle, memRdata=0xDEADBEEF -> memReq=1, stallMem=0; next edge rdWb=5, EscRegWb=1, wbData=0xDEADBEEF.
- Load miss, 3-cycle latency: memReady low for 3 cycles -> stallMem=1 for 3 cycles with bubbles rdWb=0; the 4th cycle completes with a single memReq sequence and no re-issue.
- Store: EscMemIn=1, aluIn=0x200, rs2In=0x12345678, memReady=1 -> memWe=1, memAddr=0x200, memWdata=0x12345678; EscRegWb follows EscRegIn=0.
- Branches:
  - bltIn=1, aluIn=1, immPcIn=0x40 -> flushOut=1, pcTarget=0x40.
  - bgeIn=1, aluIn=1 -> flushOut=0.
  - jalrIn=1, aluIn=0x87, pcAdd4In=0x24, rdIn=1 -> pcTarget=0x86; wbData=0x24 next edge.
- Watchdog: MAX_WAIT=4, memReady held 0 -> ERR entered after 5 WAIT cycles, memErr=1, stallMem stays 1; reset=0 for one edge clears it to IDLE.
- Reset mid-WAIT: assert reset during a pending load -> next cycle memReq=0, rdWb=0, EscRegWb=1, wbData=0.
